lane_striper: RTL
=================

# lane_striper

Byte-to-lane striping stage directly downstream of packet assembly. Accepts the serial 8-bit packet stream with a valid/ready handshake and collects NUM_LANES consecutive bytes into one symbol-time word: byte 0 goes to lane 0 and byte NUM_LANES-1 goes to the highest lane. The word is presented to the per-lane scrambler/encoder stage through a registered valid/ready output. An optional pad-flush closes partially filled words with PAD symbols.

## Interface
- NUM_LANES, 4, link width; legal values 1, 2, 4, 8
- PAD_SYM, 8'hF7, PAD symbol (K23.7) used to fill unused lanes on flush
- clk_i  input  1  clock; all logic is on the rising edge
- rst_i  input  1  reset; synchronous, active-high
- data_i  input  8  packet byte, from data_pkt_o of packet assembly
- valid_i  input  1  data_i is valid
- flush_i  input  1  close the current partial word; qualified by ready_o
- ready_o  output  1  stage can accept a byte or flush this cycle
- lane_data_o  output  NUM_LANES*8  lane n occupies bits [8n+7:8n]
- lane_k_o  output  NUM_LANES  per-lane control-symbol flag; set on PAD lanes
- lane_valid_o  output  1  lane word is valid
- lane_ready_i  input  1  downstream accepts the lane word

## Operation
- The accumulator holds NUM_LANES byte slots, a fill counter fill_q of width $clog2(NUM_LANES+1) with range 0..NUM_LANES, and acc_full_q.
- Input acceptance:
  - A byte is accepted when valid_i && ready_o.
  - The accepted byte is written to slot fill_q, and fill_q increments.
  - When fill_q reaches NUM_LANES, acc_full_q sets and fill_q returns to 0.
- Output register: lane_data_o, lane_k_o and lane_valid_o.
  - out_free = !lane_valid_o || lane_ready_i.
  - load_out = acc_full_q && out_free. On load_out, the accumulator word and its K flags move to the output register and acc_full_q clears. This happens unless the same edge completes a new word, in which case acc_full_q stays set with the new contents.
- ready_o = !acc_full_q || load_out. This is combinational from lane_ready_i and allows full throughput (one byte per cycle).
- When lane_valid_o && !lane_ready_i, lane_data_o and lane_k_o hold stable.
- On a transfer with no new load, lane_valid_o clears.
- Flush, when PAD_EN is compiled in:
  - Flush takes effect when flush_i && ready_o.
  - Any byte accepted in the same cycle is placed first.
  - If the resulting fill is 0, the flush is a no-op: a full word was just completed, or the accumulator was empty.
  - Otherwise, slots fill..NUM_LANES-1 are loaded with PAD_SYM, their K bits are set, acc_full_q sets and fill_q returns to 0.
- Data bytes always carry K=0.

## Timing
- Reset values: lane_valid_o=0, lane_data_o=0, lane_k_o=0, fill_q=0, acc_full_q=0. ready_o=1 out of reset.
- Reset mid-operation discards any partial word and any pending output word; no output beat is produced for them.
- Latency: the byte that completes a word is accepted at edge k. lane_valid_o is high after edge k+1 if out_free held in the cycle after k. Otherwise it rises on the first edge at which out_free holds.
- Sustained valid_i with lane_ready_i=1 produces one lane word every NUM_LANES cycles, plus a one-cycle initial fill latency.
- Backpressure: with lane_ready_i=0 and the output occupied, the accumulator fills once. ready_o then drops and the stage holds at most 2 words. ready_o rises in the same cycle lane_ready_i returns.
- NUM_LANES=1: every accepted byte is its own word, and acc_full_q sets every cycle.
- Simultaneous byte, flush and load in one cycle is legal. The order of effect is byte placed, then pad, then accumulator to output.

## Configuration
- LANE_STRIPER_PAD_EN defined: flush_i behaves as described in Operation, and lane_k_o reflects PAD lanes.
- LANE_STRIPER_PAD_EN undefined:
  - flush_i is ignored, and partial words stay in the accumulator until completed by data.
  - lane_k_o is tied to 0, and PAD_SYM is unused.

## Test plan
All scenarios use NUM_LANES=4.
- Reset then idle: lane_valid_o=0, lane_data_o=0, lane_k_o=0 and ready_o=1 for 10 cycles.
- Stream bytes 8'h01..8'h08 back-to-back with lane_ready_i=1. Expect two words, 32'h04030201 then 32'h08070605, with lane_valid_o rising one edge after byte 4 is accepted. ready_o never drops.
- Hold lane_ready_i=0 and stream 12 bytes:
  - ready_o drops after 8 bytes are accepted.
  - Release lane_ready_i, then expect words 04030201, 08070605 and 0C0B0A09 in order, with no loss or duplication.
- With PAD_EN, send bytes 8'hAA, 8'hBB, then flush_i together with byte 8'hCC. Expect lane_data_o=32'hF7CCBBAA and lane_k_o=4'b1000.
- With PAD_EN, assert flush_i with fill=0 (idle, or on the cycle completing a word). Expect no extra word.
  - Without PAD_EN, the 3-byte-plus-flush stimulus produces no word until a 4th byte arrives, and lane_k_o=0.
- Accept 3 bytes, assert rst_i for one cycle, then send 4 new bytes. Expect only the new word; the 3 bytes before reset never appear.

Source files
------------

// File: rtl/lane_striper.sv
// -----------------------------------------------------------------------------
// lane_striper
//
// Purpose:
//   Byte-to-lane striping stage that sits directly after packet assembly.
//   It collects NUM_LANES consecutive bytes from the serial 8-bit packet stream
//   into one symbol-time word. Byte 0 of a word lands in lane 0 and byte
//   NUM_LANES-1 lands in the highest lane. The word is then presented to the
//   per-lane scrambler/encoder stage through a registered valid/ready output.
//
// Optional feature (compile-time macro LANE_STRIPER_PAD_EN):
//   When defined, flush_i closes a partially filled word. The unused lanes are
//   filled with PAD_SYM and their K flags are set. When undefined, flush_i is
//   ignored and lane_k_o is tied to zero.
//
// Parameters:
//   NUM_LANES   link width in lanes (1, 2, 4 or 8)
//   PAD_SYM     control symbol used for padded lanes (K23.7 by default)
//
// Ports:
//   clk_i         clock, all logic on the rising edge
//   rst_i         synchronous active-high reset
//   data_i        packet byte
//   valid_i       data_i is valid
//   flush_i       close the current partial word (qualified by ready_o)
//   ready_o       stage can take a byte and/or a flush this cycle
//   lane_data_o   lane word, lane n in bits [8n+7:8n]
//   lane_k_o      per-lane control-symbol flag (set on PAD lanes)
//   lane_valid_o  lane word is valid
//   lane_ready_i  downstream accepts the lane word
// -----------------------------------------------------------------------------
module lane_striper #(
  parameter int         NUM_LANES = 4,
  parameter logic [7:0] PAD_SYM   = 8'hF7
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [7:0]             data_i,
  input  logic                   valid_i,
  input  logic                   flush_i,
  output logic                   ready_o,
  output logic [NUM_LANES*8-1:0] lane_data_o,
  output logic [NUM_LANES-1:0]   lane_k_o,
  output logic                   lane_valid_o,
  input  logic                   lane_ready_i
);

  localparam int FILL_W = $clog2(NUM_LANES + 1);
  localparam logic [FILL_W-1:0] LAST_SLOT = FILL_W'(NUM_LANES - 1);

  // Accumulator state
  logic [NUM_LANES*8-1:0] acc_data_q;
  logic [NUM_LANES*8-1:0] acc_data_d;
  logic [FILL_W-1:0]      fill_q;
  logic [FILL_W-1:0]      fill_d;
  logic [FILL_W-1:0]      fill_inc;
  logic                   acc_full_q;
  logic                   acc_full_d;

  // Handshake and control terms
  logic out_free;
  logic load_out;
  logic byte_take;
  logic word_done;
  logic pad_do;

  // The output register can take a new word when it is empty or is being
  // drained this cycle. Because lane_ready_i feeds ready_o combinationally,
  // a full accumulator can hand over its word and accept a fresh byte in the
  // same cycle, which is what sustains one byte per clock.
  assign out_free  = !lane_valid_o || lane_ready_i;
  assign load_out  = acc_full_q && out_free;
  assign ready_o   = !acc_full_q || load_out;
  assign byte_take = valid_i && ready_o;

  // A byte written into the last slot completes the word. After a full word,
  // fill_q is already zero, so new bytes start again at slot 0 while the
  // completed word waits in the accumulator for the output register.
  assign word_done = byte_take && (fill_q == LAST_SLOT);
  assign fill_inc  = byte_take ? (fill_q + FILL_W'(1)) : fill_q;

`ifdef LANE_STRIPER_PAD_EN
  logic [NUM_LANES-1:0] acc_k_q;
  logic [NUM_LANES-1:0] acc_k_d;
  logic [FILL_W-1:0]    fill_eff;

  // Fill level after the same-cycle byte is placed. A zero here means the
  // word was just completed by data or the accumulator is empty, so there is
  // nothing to pad.
  assign fill_eff = word_done ? '0 : fill_inc;
  assign pad_do   = flush_i && ready_o && (fill_eff != '0);
`else
  logic unused_pad_inputs;

  // Flush support is compiled out; these inputs only need to be absorbed.
  assign pad_do            = 1'b0;
  assign unused_pad_inputs = ^{flush_i, PAD_SYM};
`endif

  // Next accumulator contents: the incoming byte goes into slot fill_q, then
  // a flush pads every slot from the post-byte fill level upward. The two
  // never touch the same slot because the byte slot is always below fill_eff.
  always_comb begin
    acc_data_d = acc_data_q;
`ifdef LANE_STRIPER_PAD_EN
    acc_k_d    = acc_k_q;
`endif
    for (int i = 0; i < NUM_LANES; i++) begin
      if (byte_take && (fill_q == FILL_W'(i))) begin
        acc_data_d[i*8 +: 8] = data_i;
`ifdef LANE_STRIPER_PAD_EN
        acc_k_d[i]           = 1'b0;
`endif
      end
`ifdef LANE_STRIPER_PAD_EN
      if (pad_do && (FILL_W'(i) >= fill_eff)) begin
        acc_data_d[i*8 +: 8] = PAD_SYM;
        acc_k_d[i]           = 1'b1;
      end
`endif
    end
  end

  // Fill counter and full flag. A completing byte or a pad closes the word;
  // otherwise the full flag only clears once the word has moved to the output
  // register. A word closed on the same edge as a load keeps the flag set.
  always_comb begin
    acc_full_d = acc_full_q && !load_out;
    fill_d     = fill_inc;
    if (word_done || pad_do) begin
      acc_full_d = 1'b1;
      fill_d     = '0;
    end
  end

  // Accumulator registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_data_q <= '0;
      fill_q     <= '0;
      acc_full_q <= 1'b0;
    end else begin
      acc_data_q <= acc_data_d;
      fill_q     <= fill_d;
      acc_full_q <= acc_full_d;
    end
  end

`ifdef LANE_STRIPER_PAD_EN
  // K flags travel with the accumulator contents
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_k_q <= '0;
    end else begin
      acc_k_q <= acc_k_d;
    end
  end
`endif

  // Output register. The word captured on load_out is the accumulator value
  // before this edge, so a byte written into slot 0 on the same edge belongs
  // to the next word. Data and K hold while the downstream stalls.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lane_data_o  <= '0;
      lane_valid_o <= 1'b0;
    end else if (load_out) begin
      lane_data_o  <= acc_data_q;
      lane_valid_o <= 1'b1;
    end else if (lane_ready_i) begin
      lane_valid_o <= 1'b0;
    end
  end

`ifdef LANE_STRIPER_PAD_EN
  // Output K flags load alongside the lane data
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lane_k_o <= '0;
    end else if (load_out) begin
      lane_k_o <= acc_k_q;
    end
  end
`else
  assign lane_k_o = '0;
`endif

endmodule
